// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter
// Shares one Avalon-style memory bus between the CPU fetch port and the
// load/store port. The winner's request is latched in IDLE, so the bus
// outputs stay frozen while mem_waitrequest is high. Each transfer ends
// with a single *_valid pulse. The port that completed last cycle is
// masked from the next arbitration so a still-high request is not re-issued.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN (alternating priority on
// simultaneous requests; default build is fixed data-over-instr priority).
module mips_cpu_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int WAIT_LIMIT = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      instr_req,
   input  logic [ADDR_WIDTH-1:0]     instr_address,
   output logic [DATA_WIDTH-1:0]     instr_readdata,
   output logic                      instr_valid,
   input  logic                      data_read,
   input  logic                      data_write,
   input  logic [ADDR_WIDTH-1:0]     data_address,
   input  logic [DATA_WIDTH-1:0]     data_writedata,
   input  logic [DATA_WIDTH/8-1:0]   data_byteenable,
   output logic [DATA_WIDTH-1:0]     data_readdata,
   output logic                      data_valid,
   output logic [ADDR_WIDTH-1:0]     mem_address,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [DATA_WIDTH-1:0]     mem_writedata,
   output logic [DATA_WIDTH/8-1:0]   mem_byteenable,
   input  logic                      mem_waitrequest,
   input  logic [DATA_WIDTH-1:0]     mem_readdata,
   output logic                      busy,
   output logic                      wait_err
);

   localparam int BE_WIDTH  = DATA_WIDTH / 8;
   localparam int CNT_WIDTH = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(WAIT_LIMIT);
   localparam logic WD_EN = (WAIT_LIMIT > 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t                  state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0]   mem_address_r, mem_address_nxt_s;
   logic                    mem_read_r, mem_read_nxt_s;
   logic                    mem_write_r, mem_write_nxt_s;
   logic [DATA_WIDTH-1:0]   mem_writedata_r, mem_writedata_nxt_s;
   logic [BE_WIDTH-1:0]     mem_byteenable_r, mem_byteenable_nxt_s;
   logic [DATA_WIDTH-1:0]   instr_readdata_r, instr_readdata_nxt_s;
   logic [DATA_WIDTH-1:0]   data_readdata_r, data_readdata_nxt_s;
   logic                    instr_valid_r, instr_valid_nxt_s;
   logic                    data_valid_r, data_valid_nxt_s;
   logic                    busy_r, busy_nxt_s;
   logic                    wait_err_r, wait_err_nxt_s;
   logic [CNT_WIDTH-1:0]    wait_cnt_r, wait_cnt_nxt_s;
   logic [CNT_WIDTH-1:0]    cnt_inc_s;
   logic                    instr_cand_s, data_cand_s, pick_data_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                    last_grant_r, last_grant_nxt_s;   // 1 = data port granted last
`endif

   // Arbitration: mask the port that just completed, then pick a winner
   always_comb begin
      instr_cand_s = instr_req & ~instr_valid_r;
      data_cand_s  = (data_read | data_write) & ~data_valid_r;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick_data_s  = data_cand_s & (~instr_cand_s | ~last_grant_r);
`else
      pick_data_s  = data_cand_s;
`endif
      cnt_inc_s    = wait_cnt_r + CNT_WIDTH'(1);
   end

   // Next-state and next-output logic for the grant FSM
   always_comb begin
      state_nxt_s          = state_r;
      mem_address_nxt_s    = mem_address_r;
      mem_read_nxt_s       = mem_read_r;
      mem_write_nxt_s      = mem_write_r;
      mem_writedata_nxt_s  = mem_writedata_r;
      mem_byteenable_nxt_s = mem_byteenable_r;
      instr_readdata_nxt_s = instr_readdata_r;
      data_readdata_nxt_s  = data_readdata_r;
      instr_valid_nxt_s    = 1'b0;
      data_valid_nxt_s     = 1'b0;
      busy_nxt_s           = busy_r;
      wait_err_nxt_s       = wait_err_r;
      wait_cnt_nxt_s       = wait_cnt_r;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_nxt_s     = last_grant_r;
`endif
      case (state_r)
         IDLE: begin
            if (pick_data_s) begin
               // A simultaneous read+write is served as a write
               state_nxt_s          = GRANT_D;
               mem_address_nxt_s    = data_address;
               mem_write_nxt_s      = data_write;
               mem_read_nxt_s       = ~data_write;
               mem_writedata_nxt_s  = data_writedata;
               mem_byteenable_nxt_s = data_byteenable;
               busy_nxt_s           = 1'b1;
               wait_cnt_nxt_s       = {CNT_WIDTH{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
               last_grant_nxt_s     = 1'b1;
`endif
            end else if (instr_cand_s) begin
               state_nxt_s          = GRANT_I;
               mem_address_nxt_s    = instr_address;
               mem_read_nxt_s       = 1'b1;
               mem_write_nxt_s      = 1'b0;
               mem_writedata_nxt_s  = {DATA_WIDTH{1'b0}};
               mem_byteenable_nxt_s = {BE_WIDTH{1'b1}};
               busy_nxt_s           = 1'b1;
               wait_cnt_nxt_s       = {CNT_WIDTH{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
               last_grant_nxt_s     = 1'b0;
`endif
            end else begin
               busy_nxt_s           = 1'b0;
            end
         end
         GRANT_I, GRANT_D: begin
            if (!mem_waitrequest) begin
               state_nxt_s     = IDLE;
               mem_read_nxt_s  = 1'b0;
               mem_write_nxt_s = 1'b0;
               busy_nxt_s      = 1'b0;
               wait_cnt_nxt_s  = {CNT_WIDTH{1'b0}};
               if (state_r == GRANT_I) begin
                  instr_valid_nxt_s    = 1'b1;
                  instr_readdata_nxt_s = mem_readdata;
               end else begin
                  data_valid_nxt_s = 1'b1;
                  // A store ack leaves the last load data in place
                  if (mem_read_r) begin
                     data_readdata_nxt_s = mem_readdata;
                  end else begin
                     data_readdata_nxt_s = data_readdata_r;
                  end
               end
            end else begin
               // Stalled: hold the bus and run the watchdog (saturating)
               if (WD_EN && (wait_cnt_r != CNT_LIMIT)) begin
                  wait_cnt_nxt_s = cnt_inc_s;
                  if (cnt_inc_s == CNT_LIMIT) begin
                     wait_err_nxt_s = 1'b1;
                  end else begin
                     wait_err_nxt_s = wait_err_r;
                  end
               end else begin
                  wait_cnt_nxt_s = wait_cnt_r;
               end
            end
         end
         default: begin
            state_nxt_s     = IDLE;
            mem_read_nxt_s  = 1'b0;
            mem_write_nxt_s = 1'b0;
            busy_nxt_s      = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Registered bus, response and status outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_address_r    <= {ADDR_WIDTH{1'b0}};
         mem_read_r       <= 1'b0;
         mem_write_r      <= 1'b0;
         mem_writedata_r  <= {DATA_WIDTH{1'b0}};
         mem_byteenable_r <= {BE_WIDTH{1'b0}};
         instr_readdata_r <= {DATA_WIDTH{1'b0}};
         data_readdata_r  <= {DATA_WIDTH{1'b0}};
         instr_valid_r    <= 1'b0;
         data_valid_r     <= 1'b0;
         busy_r           <= 1'b0;
         wait_err_r       <= 1'b0;
         wait_cnt_r       <= {CNT_WIDTH{1'b0}};
      end else begin
         mem_address_r    <= mem_address_nxt_s;
         mem_read_r       <= mem_read_nxt_s;
         mem_write_r      <= mem_write_nxt_s;
         mem_writedata_r  <= mem_writedata_nxt_s;
         mem_byteenable_r <= mem_byteenable_nxt_s;
         instr_readdata_r <= instr_readdata_nxt_s;
         data_readdata_r  <= data_readdata_nxt_s;
         instr_valid_r    <= instr_valid_nxt_s;
         data_valid_r     <= data_valid_nxt_s;
         busy_r           <= busy_nxt_s;
         wait_err_r       <= wait_err_nxt_s;
         wait_cnt_r       <= wait_cnt_nxt_s;
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Remembers which port won most recently; starts as instr so data wins first
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant_r <= 1'b0;
      end else begin
         last_grant_r <= last_grant_nxt_s;
      end
   end
`endif

   assign mem_address    = mem_address_r;
   assign mem_read       = mem_read_r;
   assign mem_write      = mem_write_r;
   assign mem_writedata  = mem_writedata_r;
   assign mem_byteenable = mem_byteenable_r;
   assign instr_readdata = instr_readdata_r;
   assign data_readdata  = data_readdata_r;
   assign instr_valid    = instr_valid_r;
   assign data_valid     = data_valid_r;
   assign busy           = busy_r;
   assign wait_err       = wait_err_r;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Self-checking bench for mips_cpu_mem_arbiter (WAIT_LIMIT = 4).
// Expected completions are pushed to a scoreboard queue when a request is
// driven and popped when the matching *_valid pulse appears.
module tb_mips_cpu_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int WL = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          instr_req;
   logic [AW-1:0] instr_address;
   logic [DW-1:0] instr_readdata;
   logic          instr_valid;
   logic          data_read, data_write;
   logic [AW-1:0] data_address;
   logic [DW-1:0] data_writedata;
   logic [BW-1:0] data_byteenable;
   logic [DW-1:0] data_readdata;
   logic          data_valid;
   logic [AW-1:0] mem_address;
   logic          mem_read, mem_write;
   logic [DW-1:0] mem_writedata;
   logic [BW-1:0] mem_byteenable;
   logic          mem_waitrequest;
   logic [DW-1:0] mem_readdata;
   logic          busy, wait_err;

   mips_cpu_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
      .clk(clk), .reset(reset),
      .instr_req(instr_req), .instr_address(instr_address),
      .instr_readdata(instr_readdata), .instr_valid(instr_valid),
      .data_read(data_read), .data_write(data_write), .data_address(data_address),
      .data_writedata(data_writedata), .data_byteenable(data_byteenable),
      .data_readdata(data_readdata), .data_valid(data_valid),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
      .busy(busy), .wait_err(wait_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          is_data;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          e;
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] m_ird, m_drd;     // model of held read data per port
   logic          m_last_data;      // model of most recent grant (1 = data)

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      instr_req = 1'b0; instr_address = 32'h0;
      data_read = 1'b0; data_write = 1'b0; data_address = 32'h0;
      data_writedata = 32'h0; data_byteenable = 4'h0;
      mem_waitrequest = 1'b0; mem_readdata = 32'h0;
   endtask

   task automatic apply_reset;
      reset = 1'b1;
      clear_inputs();
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      m_ird = 32'h0; m_drd = 32'h0; m_last_data = 1'b0;
      tick();
   endtask

   task automatic test_reset;
      reset = 1'b1;
      clear_inputs();
      #2;
      checks++;
      if ({mem_read, mem_write, busy, instr_valid, data_valid, wait_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 000000",
                  {mem_read, mem_write, busy, instr_valid, data_valid, wait_err});
      end
      checks++;
      if ({mem_address, mem_writedata, mem_byteenable} !== 68'h0) begin
         errors++;
         $display("FAIL reset_bus got %h %h %h want zeros", mem_address, mem_writedata, mem_byteenable);
      end
      checks++;
      if ({instr_readdata, data_readdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h %h want zeros", instr_readdata, data_readdata);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_ird = 32'h0; m_drd = 32'h0; m_last_data = 1'b0;
      tick();
   endtask

   task automatic test_fetch;
      instr_req = 1'b1; instr_address = 32'hBFC00000;
      mem_waitrequest = 1'b0; mem_readdata = 32'h24020005;
      exp_q.push_back('{1'b0, 32'h24020005}); m_ird = 32'h24020005;
      tick();  // cycle 1
      checks++;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'hBFC00000 ||
          mem_byteenable !== 4'hF || busy !== 1'b1) begin
         errors++;
         $display("FAIL fetch_strobe got rd=%b wr=%b a=%h be=%h busy=%b want 1 0 bfc00000 f 1",
                  mem_read, mem_write, mem_address, mem_byteenable, busy);
      end
      tick();  // cycle 2
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL fetch_sb got empty queue want entry");
      end else begin
         e = exp_q.pop_front();
         if ({instr_valid, data_valid} !== 2'b10 || instr_readdata !== e.rdata) begin
            errors++;
            $display("FAIL fetch_done got v=%b%b d=%h want 10 %h", instr_valid, data_valid, instr_readdata, e.rdata);
         end
      end
      tick();  // cycle 3: request still high but masked last cycle
      checks++;
      if (mem_read !== 1'b0 || busy !== 1'b0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL fetch_no_reissue got rd=%b busy=%b v=%b want 0 0 0", mem_read, busy, instr_valid);
      end
      instr_req = 1'b0;
      tick();
   endtask

   task automatic test_write;
      data_write = 1'b1; data_address = 32'h1000; data_writedata = 32'hDEADBEEF;
      data_byteenable = 4'h3; mem_waitrequest = 1'b1;
      exp_q.push_back('{1'b1, m_drd});
      for (int k = 1; k <= 4; k++) begin
         tick();
         mem_waitrequest = (k <= 3);
         checks++;
         if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h1000 ||
             mem_writedata !== 32'hDEADBEEF || mem_byteenable !== 4'h3 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_hold[%0d] got wr=%b rd=%b a=%h d=%h be=%h v=%b want 1 0 1000 deadbeef 3 0",
                     k, mem_write, mem_read, mem_address, mem_writedata, mem_byteenable, data_valid);
         end
      end
      tick();
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL write_sb got empty queue want entry");
      end else begin
         e = exp_q.pop_front();
         if ({instr_valid, data_valid} !== 2'b01 || data_readdata !== e.rdata) begin
            errors++;
            $display("FAIL write_ack got v=%b%b d=%h want 01 %h", instr_valid, data_valid, data_readdata, e.rdata);
         end
      end
      data_write = 1'b0;
      tick();
      checks++;
      if (data_valid !== 1'b0 || mem_write !== 1'b0) begin
         errors++; $display("FAIL write_single_pulse got v=%b wr=%b want 0 0", data_valid, mem_write);
      end
      m_last_data = 1'b1;
   endtask

   task automatic test_pair(input logic [AW-1:0] ia, input logic [AW-1:0] da,
                            input logic [DW-1:0] ird, input logic [DW-1:0] drd);
      logic first_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      first_data = ~m_last_data;
`else
      first_data = 1'b1;
`endif
      instr_req = 1'b1; instr_address = ia;
      data_read = 1'b1; data_write = 1'b0; data_address = da; data_byteenable = 4'hF;
      mem_waitrequest = 1'b0;
      mem_readdata = first_data ? drd : ird;
      exp_q.push_back(first_data ? exp_t'{1'b1, drd} : exp_t'{1'b0, ird});
      exp_q.push_back(first_data ? exp_t'{1'b0, ird} : exp_t'{1'b1, drd});
      m_ird = ird; m_drd = drd;
      tick();  // cycle 1: first winner on the bus
      checks++;
      if (mem_read !== 1'b1 || mem_address !== (first_data ? da : ia)) begin
         errors++;
         $display("FAIL pair_grant1 got rd=%b a=%h want 1 %h", mem_read, mem_address, first_data ? da : ia);
      end
      tick();  // cycle 2: first completion, other port arbitrated now
      for (int n = 0; n < 2; n++) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++; $display("FAIL pair_sb%0d got empty queue want entry", n);
         end else begin
            e = exp_q.pop_front();
            if ({instr_valid, data_valid} !== (e.is_data ? 2'b01 : 2'b10) ||
                (e.is_data ? data_readdata : instr_readdata) !== e.rdata) begin
               errors++;
               $display("FAIL pair_done%0d got v=%b%b i=%h d=%h want data=%b %h",
                        n, instr_valid, data_valid, instr_readdata, data_readdata, e.is_data, e.rdata);
            end
         end
         if (n == 0) begin
            if (first_data) data_read = 1'b0; else instr_req = 1'b0;
            mem_readdata = first_data ? ird : drd;
            tick();  // cycle 3: second winner on the bus
            checks++;
            if (mem_read !== 1'b1 || mem_address !== (first_data ? ia : da)) begin
               errors++;
               $display("FAIL pair_grant2 got rd=%b a=%h want 1 %h", mem_read, mem_address, first_data ? ia : da);
            end
            tick();  // cycle 4: second completion
         end
      end
      instr_req = 1'b0; data_read = 1'b0;
      m_last_data = ~first_data;
      tick();
   endtask

   task automatic test_arbitration;
      apply_reset();
      test_pair(32'h0000_0A00, 32'h0000_0D00, 32'h1111_1111, 32'h2222_2222);
      // A lone store makes data the most recent grant
      data_write = 1'b1; data_address = 32'h5000; data_writedata = 32'h12345678;
      data_byteenable = 4'hF; mem_waitrequest = 1'b0;
      exp_q.push_back('{1'b1, m_drd});
      tick();
      tick();
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL store_sb got empty queue want entry");
      end else begin
         e = exp_q.pop_front();
         if (data_valid !== 1'b1 || data_readdata !== e.rdata) begin
            errors++; $display("FAIL store_ack got v=%b d=%h want 1 %h", data_valid, data_readdata, e.rdata);
         end
      end
      data_write = 1'b0;
      m_last_data = 1'b1;
      tick();
      test_pair(32'h0000_0A04, 32'h0000_0D04, 32'h3333_3333, 32'h4444_4444);
   endtask

   task automatic test_reset_mid;
      data_read = 1'b1; data_address = 32'h2000; data_byteenable = 4'hF; mem_waitrequest = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1 || mem_read !== 1'b1) begin
         errors++; $display("FAIL midrst_grant got busy=%b rd=%b want 1 1", busy, mem_read);
      end
      tick();
      reset = 1'b1;
      data_read = 1'b0;
      #1;
      checks++;
      if ({mem_read, mem_write, busy, data_valid} !== 4'b0) begin
         errors++; $display("FAIL midrst_async got %b want 0000", {mem_read, mem_write, busy, data_valid});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      m_ird = 32'h0; m_drd = 32'h0; m_last_data = 1'b0;
      mem_waitrequest = 1'b0;
      tick();
      tick();
      checks++;
      if (data_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_no_valid got v=%b busy=%b want 0 0", data_valid, busy);
      end
      data_read = 1'b1; data_address = 32'h3000; mem_readdata = 32'hCAFEF00D;
      exp_q.push_back('{1'b1, 32'hCAFEF00D}); m_drd = 32'hCAFEF00D;
      tick();
      tick();
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL midrst_sb got empty queue want entry");
      end else begin
         e = exp_q.pop_front();
         if (data_valid !== 1'b1 || data_readdata !== e.rdata) begin
            errors++; $display("FAIL midrst_fresh got v=%b d=%h want 1 %h", data_valid, data_readdata, e.rdata);
         end
      end
      data_read = 1'b0;
      tick();
   endtask

   task automatic test_watchdog;
      instr_req = 1'b1; instr_address = 32'h4000; mem_readdata = 32'h0BADF00D;
      exp_q.push_back('{1'b0, 32'h0BADF00D}); m_ird = 32'h0BADF00D;
      for (int k = 1; k <= 7; k++) begin
         tick();
         mem_waitrequest = (k <= 6);
         checks++;
         if (wait_err !== (k >= 5) || mem_read !== 1'b1 || mem_address !== 32'h4000) begin
            errors++;
            $display("FAIL wd_cycle[%0d] got err=%b rd=%b a=%h want %b 1 4000",
                     k, wait_err, mem_read, mem_address, (k >= 5));
         end
      end
      tick();
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL wd_sb got empty queue want entry");
      end else begin
         e = exp_q.pop_front();
         if (instr_valid !== 1'b1 || instr_readdata !== e.rdata || wait_err !== 1'b1) begin
            errors++;
            $display("FAIL wd_done got v=%b d=%h err=%b want 1 %h 1", instr_valid, instr_readdata, wait_err, e.rdata);
         end
      end
      instr_req = 1'b0;
      tick();
      tick();
      checks++;
      if (wait_err !== 1'b1) begin
         errors++; $display("FAIL wd_sticky got %b want 1", wait_err);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (wait_err !== 1'b0) begin
         errors++; $display("FAIL wd_reset_clear got %b want 0", wait_err);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got no finish want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_fetch();
      test_write();
      test_arbitration();
      test_reset_mid();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_cpu_mem_arbiter.md
Name: mips_cpu_mem_arbiter

Overview:
Shares one Avalon-style memory bus between the CPU instruction-fetch port and the data port, for the bus-based CPU variant.
- Stalls either requester until its transfer completes.
- Holds bus outputs stable under mem_waitrequest.
- Returns read data and a one-cycle valid/ack pulse per transfer.
- Sits between the CPU core (PC/fetch and load/store paths) and the external memory bus.

Parameters:
ADDR_WIDTH, 32, width of all address ports
DATA_WIDTH, 32, width of all data ports; byteenable width is DATA_WIDTH/8
WAIT_LIMIT, 0, watchdog limit on consecutive mem_waitrequest cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-high
instr_req  in  1  fetch request; held high until instr_valid
instr_address  in  ADDR_WIDTH  fetch address
instr_readdata  out  DATA_WIDTH  captured fetch data
instr_valid  out  1  one-cycle fetch-complete pulse
data_read  in  1  load request; held until data_valid
data_write  in  1  store request; held until data_valid
data_address  in  ADDR_WIDTH  load/store address
data_writedata  in  DATA_WIDTH  store data
data_byteenable  in  DATA_WIDTH/8  store/load lane enables
data_readdata  out  DATA_WIDTH  captured load data
data_valid  out  1  one-cycle load-complete / store-ack pulse
mem_address  out  ADDR_WIDTH  bus address
mem_read  out  1  bus read strobe
mem_write  out  1  bus write strobe
mem_writedata  out  DATA_WIDTH  bus write data
mem_byteenable  out  DATA_WIDTH/8  bus lane enables
mem_waitrequest  in  1  bus stall; transfer completes in a granted cycle where this is 0
mem_readdata  in  DATA_WIDTH  bus read data, valid in the completion cycle
busy  out  1  high in any GRANT state
wait_err  out  1  sticky watchdog flag

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; all mem_* outputs 0; instr_valid, data_valid, busy, wait_err 0; instr_readdata and data_readdata 0. An in-flight bus transfer is abandoned.
- All outputs are registered.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - Sample requests; the port that completed in the previous cycle is masked.
  - Winner's address, data and enables are latched into the mem_* registers; the strobe asserts the next cycle together with the GRANT state.
  - Both ports requesting: data wins (fixed priority).
  - data_read and data_write both high: treated as a write.
  - Instruction fetch drives mem_read=1 and mem_byteenable all ones.
- GRANT_x:
  - mem_* outputs are held constant while mem_waitrequest=1.
  - Completion is the first GRANT cycle with mem_waitrequest=0.
  - On completion, the next edge: strobes drop to 0, state goes to IDLE, the served port's *_valid=1 for exactly one cycle.
  - For reads, *_readdata takes mem_readdata captured at completion and holds it until that port's next read completion.
  - A write ack leaves data_readdata unchanged.
- Latency: request seen in IDLE at cycle 0 → strobe in cycle 1 → with zero wait, valid in cycle 2. Each wait cycle adds one cycle.
- Masking: during the *_valid cycle the requester must drop or advance its request; the completed port is excluded from that IDLE cycle's arbitration, so a still-high request is not re-issued. The other port may be granted in that cycle.
- Request changes during GRANT are ignored; only latched values drive the bus.
- Watchdog: when WAIT_LIMIT>0, a counter increments on each granted cycle with mem_waitrequest=1 and clears on completion. Reaching WAIT_LIMIT sets wait_err, which is cleared only by reset; the transfer continues waiting.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN:
- Defined: a last_grant register is added (reset value = instr). On simultaneous requests in IDLE, the port not most recently granted wins. Consequence: data wins first after reset, then grants alternate.
- Undefined: fixed priority, data over instr; no last_grant register.

Test Plan:
- instr_req=1, address 0xBFC00000, waitrequest=0, mem_readdata=0x24020005 → mem_read=1 with mem_address=0xBFC00000 in cycle 1; instr_valid=1 and instr_readdata=0x24020005 in cycle 2; no second fetch issued while req stays high in cycle 2.
- data_write=1, addr 0x1000, wdata 0xDEADBEEF, byteenable 0x3, waitrequest high for 3 cycles → bus outputs stable for 4 granted cycles; data_valid pulses once; data_readdata unchanged.
- instr_req and data_read asserted together → data granted first, instr granted in the data_valid cycle; instr_valid follows 2 cycles later. With MEM_ARB_ROUND_ROBIN_EN, a second simultaneous pair grants instr first.
- reset pulsed mid-GRANT_D with waitrequest=1 → mem_read/mem_write/busy go to 0 immediately, no valid pulse; a fresh request after reset completes normally.
- WAIT_LIMIT=4, waitrequest held 6 cycles → wait_err=1 after the 4th wait cycle; transfer still completes with valid; wait_err stays 1 until reset.
